slot_allocator32: RTL and testbench

// - 32-entry slot/tag allocator: holds a free bitmap and hands out the lowest-index free slot each cycle.
// - Drives find_first_set32 with the free bitmap and consumes its index output.
// - Hands tags to requesters (valid/ready) and takes returned tags back; zero-bubble back-to-back allocation.

---
 rtl/slot_allocator32.sv | 145 ++++++++++++++
 tb/tb_slot_allocator32.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/slot_allocator32.sv
// slot_allocator32: 32-entry slot/tag allocator with a free bitmap and a lowest-index-first offer.
// Contains find_first_set32, the priority encoder it drives with the next free bitmap.
// Optional feature: define ALLOC_HIGH_WATER_EN to add the high_water occupancy output.

// Lowest-set-bit encoder; both IMPLEMENTATION variants give identical results.
module find_first_set32 #(
  parameter string IMPLEMENTATION = "LOW"
) (
  input  logic [31:0] bits,
  output logic        valid,
  output logic [4:0]  index
);
  if (IMPLEMENTATION == "LOW") begin : g_low
    logic found;
    // Ascending scan; the first hit locks the result
    always_comb begin
      index = '0;
      found = 1'b0;
      for (int i = 0; i < 32; i++) begin
        if (!found && bits[i]) begin
          index = 5'(i);
          found = 1'b1;
        end
      end
    end
    assign valid = |bits;
  end else if (IMPLEMENTATION == "HIGH") begin : g_high
    // Descending scan; later (lower) hits overwrite earlier ones
    always_comb begin
      index = '0;
      for (int i = 31; i >= 0; i--) begin
        if (bits[i]) index = 5'(i);
      end
    end
    assign valid = |bits;
  end else begin : g_bad
    $error("find_first_set32: IMPLEMENTATION must be \"LOW\" or \"HIGH\"");
    assign valid = 1'b0;
    assign index = '0;
  end
endmodule

module slot_allocator32 #(
  parameter string       IMPLEMENTATION  = "LOW",
  parameter logic [31:0] RESET_FREE_MASK = 32'hFFFF_FFFF
) (
  input  logic       clk,
  input  logic       rst,
  output logic       alloc_valid,
  output logic [4:0] alloc_id,
  input  logic       alloc_ready,
  input  logic       free_valid,
  input  logic [4:0] free_id,
  output logic       free_err,
`ifdef ALLOC_HIGH_WATER_EN
  output logic [5:0] high_water,
`endif
  output logic [5:0] free_count
);
  localparam int unsigned NUM_SLOTS = 32;
  localparam int unsigned CNT_W     = 6;

  // Reset-time constants derived from the mask
  function automatic logic [4:0] ffs_const(input logic [31:0] m);
    logic [4:0] r;
    r = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (m[i]) r = 5'(i);
    end
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] pop32(input logic [31:0] m);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_SLOTS; i++) c = c + CNT_W'(m[i]);
    return c;
  endfunction

  localparam logic             RST_VALID = |RESET_FREE_MASK;
  localparam logic [4:0]       RST_ID    = ffs_const(RESET_FREE_MASK);
  localparam logic [CNT_W-1:0] RST_COUNT = pop32(RESET_FREE_MASK);

  logic [31:0]      free_map;
  logic [31:0]      next_map;
  logic             next_err;
  logic             handshake;
  logic             next_valid;
  logic [4:0]       next_id;
  logic [CNT_W-1:0] next_count;

  assign handshake = alloc_valid & alloc_ready;

  // Next bitmap: free sets its bit, then an accepted alloc clears its bit (alloc wins on same id)
  always_comb begin
    next_map = free_map;
    next_err = 1'b0;
    if (free_valid) begin
      next_err          = free_map[free_id];
      next_map[free_id] = 1'b1;
    end
    if (handshake) begin
      next_map[alloc_id] = 1'b0;
    end
  end

  find_first_set32 #(.IMPLEMENTATION(IMPLEMENTATION)) u_ffs (
    .bits  (next_map),
    .valid (next_valid),
    .index (next_id)
  );

  assign next_count = pop32(next_map);

  // Bitmap and registered offer/status outputs, all derived from the next bitmap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      free_map    <= RESET_FREE_MASK;
      alloc_valid <= RST_VALID;
      alloc_id    <= RST_ID;
      free_err    <= 1'b0;
      free_count  <= RST_COUNT;
    end else begin
      free_map    <= next_map;
      alloc_valid <= next_valid;
      alloc_id    <= next_valid ? next_id : 5'd0;
      free_err    <= next_err;
      free_count  <= next_count;
    end
  end

`ifdef ALLOC_HIGH_WATER_EN
  logic [CNT_W-1:0] in_use;
  assign in_use = CNT_W'(NUM_SLOTS) - free_count;

  // Peak occupancy since reset, tracking the registered count one cycle behind
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      high_water <= CNT_W'(NUM_SLOTS) - RST_COUNT;
    end else if (in_use > high_water) begin
      high_water <= in_use;
    end
  end
`endif
endmodule

// File: tb/tb_slot_allocator32.sv
// Directed-vector and scoreboard bench for slot_allocator32 (LOW/HIGH variants, custom reset mask).
module tb_slot_allocator32;
  logic       clk = 1'b0;
  logic       rst;
  logic       ar, fv;
  logic [4:0] fid;
  logic       ar2;

  logic       v0, v1, v2, e0, e1, e2;
  logic [4:0] id0, id1, id2;
  logic [5:0] c0, c1, c2;
`ifdef ALLOC_HIGH_WATER_EN
  logic [5:0] hw0, hw1, hw2;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  slot_allocator32 #(.IMPLEMENTATION("LOW")) dut0 (
    .clk(clk), .rst(rst), .alloc_valid(v0), .alloc_id(id0), .alloc_ready(ar),
    .free_valid(fv), .free_id(fid), .free_err(e0),
`ifdef ALLOC_HIGH_WATER_EN
    .high_water(hw0),
`endif
    .free_count(c0));

  slot_allocator32 #(.IMPLEMENTATION("HIGH")) dut1 (
    .clk(clk), .rst(rst), .alloc_valid(v1), .alloc_id(id1), .alloc_ready(ar),
    .free_valid(fv), .free_id(fid), .free_err(e1),
`ifdef ALLOC_HIGH_WATER_EN
    .high_water(hw1),
`endif
    .free_count(c1));

  slot_allocator32 #(.IMPLEMENTATION("LOW"), .RESET_FREE_MASK(32'h0000_0100)) dut2 (
    .clk(clk), .rst(rst), .alloc_valid(v2), .alloc_id(id2), .alloc_ready(ar2),
    .free_valid(1'b0), .free_id(5'd0), .free_err(e2),
`ifdef ALLOC_HIGH_WATER_EN
    .high_water(hw2),
`endif
    .free_count(c2));

  typedef struct {
    logic       ar;
    logic       fv;
    logic [4:0] fid;
    logic       ev;
    logic [4:0] eid;
    logic       eerr;
    logic [5:0] ecnt;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Compare both default-mask instances against one expectation
  task automatic chk_out(input string tag, input logic v, input logic [4:0] id,
                         input logic err, input logic [5:0] cnt);
    chk({tag, " valid.low"},  32'(v0),  32'(v));
    chk({tag, " id.low"},     32'(id0), 32'(id));
    chk({tag, " err.low"},    32'(e0),  32'(err));
    chk({tag, " count.low"},  32'(c0),  32'(cnt));
    chk({tag, " valid.high"}, 32'(v1),  32'(v));
    chk({tag, " id.high"},    32'(id1), 32'(id));
    chk({tag, " err.high"},   32'(e1),  32'(err));
    chk({tag, " count.high"}, 32'(c1),  32'(cnt));
  endtask

  task automatic step(input logic a, input logic f, input logic [4:0] id);
    ar  = a;
    fv  = f;
    fid = id;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] model_ffs(input logic [31:0] m);
    logic [4:0] r;
    r = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (m[i]) begin
        r = 5'(i);
        break;
      end
    end
    return r;
  endfunction

  logic [31:0] m, mn, owned;
  logic        merr, hs;
  logic [4:0]  mid;
  logic [5:0]  mhw, mcnt;

  initial begin
    // ar, fv, fid -> valid, id, err, count ; starts from an empty bitmap
    vecs[0]  = '{1'b0, 1'b1, 5'd7, 1'b1, 5'd7, 1'b0, 6'd1};
    vecs[1]  = '{1'b0, 1'b1, 5'd3, 1'b1, 5'd3, 1'b0, 6'd2};
    vecs[2]  = '{1'b0, 1'b1, 5'd5, 1'b1, 5'd3, 1'b0, 6'd3};
    vecs[3]  = '{1'b0, 1'b1, 5'd5, 1'b1, 5'd3, 1'b1, 6'd3};
    vecs[4]  = '{1'b0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b0, 6'd3};
    vecs[5]  = '{1'b1, 1'b1, 5'd9, 1'b1, 5'd5, 1'b0, 6'd3};
    vecs[6]  = '{1'b0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 6'd4};
    vecs[7]  = '{1'b1, 1'b1, 5'd0, 1'b1, 5'd5, 1'b1, 6'd3};
    vecs[8]  = '{1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 6'd3};
    vecs[9]  = '{1'b0, 1'b1, 5'd2, 1'b1, 5'd2, 1'b0, 6'd4};
    vecs[10] = '{1'b1, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 6'd3};
    vecs[11] = '{1'b1, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 6'd2};
    vecs[12] = '{1'b1, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0, 6'd1};
    vecs[13] = '{1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 6'd0};
    vecs[14] = '{1'b0, 1'b1, 5'd2, 1'b1, 5'd2, 1'b0, 6'd1};
    vecs[15] = '{1'b1, 1'b1, 5'd9, 1'b1, 5'd9, 1'b0, 6'd1};
    vecs[16] = '{1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 6'd0};
    vecs[17] = '{1'b1, 1'b1, 5'd4, 1'b1, 5'd4, 1'b0, 6'd1};
    vecs[18] = '{1'b0, 1'b0, 5'd0, 1'b1, 5'd4, 1'b0, 6'd1};

    rst = 1'b1; ar = 1'b0; fv = 1'b0; fid = 5'd0; ar2 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk_out("reset", 1'b1, 5'd0, 1'b0, 6'd32);
    chk("reset mask valid", 32'(v2), 32'd1);
    chk("reset mask id", 32'(id2), 32'd8);
    chk("reset mask count", 32'(c2), 32'd1);
`ifdef ALLOC_HIGH_WATER_EN
    chk("reset hw", 32'(hw0), 32'd0);
    chk("reset mask hw", 32'(hw2), 32'd31);
`endif

    // Free while full: error pulse, map unchanged; custom-mask instance allocates its only slot
    ar2 = 1'b1;
    step(1'b0, 1'b1, 5'd31);
    ar2 = 1'b0;
    chk_out("full free", 1'b1, 5'd0, 1'b1, 6'd32);
    chk("mask alloc valid", 32'(v2), 32'd0);
    chk("mask alloc id", 32'(id2), 32'd0);
    chk("mask alloc count", 32'(c2), 32'd0);
    step(1'b0, 1'b0, 5'd0);
    chk_out("err pulse end", 1'b1, 5'd0, 1'b0, 6'd32);

    // Back-to-back allocation of every slot in index order
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 1'b0, 5'd0);
      if (i < 31) chk_out("alloc seq", 1'b1, 5'(i + 1), 1'b0, 6'(31 - i));
      else        chk_out("alloc empty", 1'b0, 5'd0, 1'b0, 6'd0);
    end

    for (int i = 0; i < 19; i++) begin
      step(vecs[i].ar, vecs[i].fv, vecs[i].fid);
      chk_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eid, vecs[i].eerr, vecs[i].ecnt);
    end
`ifdef ALLOC_HIGH_WATER_EN
    chk("hw after drain", 32'(hw0), 32'd32);
    chk("hw after drain high", 32'(hw1), 32'd32);
`endif

    // Scoreboard phase from a fresh reset
    ar = 1'b0; fv = 1'b0;
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    m = 32'hFFFF_FFFF; owned = '0; mhw = 6'd0;
    for (int n = 0; n < 20000; n++) begin
      logic a, f;
      logic [4:0] id;
      a  = 1'($urandom_range(0, 1));
      f  = ($urandom_range(0, 3) != 0);
      id = 5'($urandom_range(0, 31));
      hs = a & (m != 32'd0);
      mid = model_ffs(m);
      mcnt = 6'($countones(m));
      if (6'd32 - mcnt > mhw) mhw = 6'd32 - mcnt;
      if (hs) begin
        chk("unique handout", 32'(owned[mid]), 32'd0);
        owned[mid] = 1'b1;
      end
      mn = m;
      merr = f & m[id];
      if (f) begin
        mn[id] = 1'b1;
        owned[id] = 1'b0;
      end
      if (hs) begin
        mn[mid] = 1'b0;
        owned[mid] = 1'b1;
      end
      m = mn;
      step(a, f, id);
      chk_out("random", m != 32'd0, model_ffs(m), merr, 6'($countones(m)));
`ifdef ALLOC_HIGH_WATER_EN
      chk("random hw", 32'(hw0), 32'(mhw));
`endif
    end

    // Asynchronous reset mid-run, checked before any clock edge
    ar = 1'b0; fv = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_out("async reset", 1'b1, 5'd0, 1'b0, 6'd32);
    chk("async mask valid", 32'(v2), 32'd1);
    chk("async mask id", 32'(id2), 32'd8);
    chk("async mask count", 32'(c2), 32'd1);
`ifdef ALLOC_HIGH_WATER_EN
    chk("async hw", 32'(hw0), 32'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
